// File: rtl/mem_proto_pkg.sv
// Shared definitions for the cache-to-memory line protocol: FSM states,
// default geometry and line sizing.
package mem_proto_pkg;

    localparam int unsigned LINE_ADDR_LEN_DEF = 3;
    localparam int unsigned ADDR_LEN_DEF      = 10;
    localparam int unsigned WORD_W            = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } mem_state_e;

    function automatic int unsigned line_size(input int unsigned line_addr_len);
        return 32'd1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Line-granular memory bus between the cache (master) and the memory
// responder (slave).
interface line_mem_responder_if
    import mem_proto_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned ADDR_LEN      = ADDR_LEN_DEF
);
    localparam int LINE_SIZE = int'(line_size(LINE_ADDR_LEN));

    logic                gnt;
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic [WORD_W-1:0]   rd_line [LINE_SIZE];
    logic                wr_req;
    logic [WORD_W-1:0]   wr_line [LINE_SIZE];
    logic                busy;

    modport master (
        input  gnt, rd_line, busy,
        output addr, rd_req, wr_req, wr_line
    );

    modport slave (
        output gnt, rd_line, busy,
        input  addr, rd_req, wr_req, wr_line
    );

endinterface

// File: rtl/line_mem_array.sv
// Line-wide storage with one write port and one registered read port.
// Each line powers up holding its own word addresses.
module line_mem_array
    import mem_proto_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned ADDR_LEN      = ADDR_LEN_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ADDR_LEN-1:0]                          addr,
    input  logic                                         we,
    input  logic [line_size(LINE_ADDR_LEN)*WORD_W-1:0]   wdata,
    input  logic                                         re,
    output logic [line_size(LINE_ADDR_LEN)*WORD_W-1:0]   rdata
);
    localparam int LINE_SIZE = int'(line_size(LINE_ADDR_LEN));
    localparam int LINE_W    = LINE_SIZE * int'(WORD_W);
    localparam int DEPTH     = 1 << ADDR_LEN;

    function automatic logic [LINE_W-1:0] init_line(input int unsigned a);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int w = 0; w < LINE_SIZE; w++) begin
            l[w*WORD_W +: WORD_W] = WORD_W'((a << LINE_ADDR_LEN) + unsigned'(w));
        end
        return l;
    endfunction

    logic [LINE_W-1:0] lines [DEPTH];
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] rdata_d;

    // Storage is deliberately outside the reset domain: rst must not lose contents.
    for (genvar a = 0; a < DEPTH; a++) begin : g_line
        logic [LINE_W-1:0] line_q = init_line(a);
        logic [LINE_W-1:0] line_d;

        always_comb begin
            line_d = line_q;
            if (we && addr == ADDR_LEN'(a)) line_d = wdata;
        end

        always_ff @(posedge clk) begin
            line_q <= line_d;
        end

        assign lines[a] = line_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = lines[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Slow main-memory model: accepts one whole-line read or write, waits a fixed
// latency, commits or fetches the line, then pulses gnt for one cycle.
module line_mem_responder
    import mem_proto_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned ADDR_LEN      = ADDR_LEN_DEF,
    parameter int unsigned RD_LATENCY    = 50,
    parameter int unsigned WR_LATENCY    = 50
) (
    input logic                 clk,
    input logic                 rst,
    line_mem_responder_if.slave bus
);
    localparam int          LINE_SIZE = int'(line_size(LINE_ADDR_LEN));
    localparam int          LINE_W    = LINE_SIZE * int'(WORD_W);
    localparam int unsigned MAX_LAT   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int          CNT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);

    mem_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                is_wr_q, is_wr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic                commit;
    logic                mem_we;
    logic                mem_re;
    logic [LINE_W-1:0]   mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request snapshot: later changes on addr/wr_line must not reach the array.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        is_wr_q <= is_wr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    state_d = WAIT;
                    addr_d  = bus.addr;
                    is_wr_d = bus.wr_req;
                    cnt_d   = bus.wr_req ? WR_CNT_INIT : RD_CNT_INIT;
                    for (int w = 0; w < LINE_SIZE; w++) begin
                        wdata_d[w*WORD_W +: WORD_W] = bus.wr_line[w];
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = GRANT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt  = (state_q == GRANT);
        bus.busy = (state_q != IDLE);
        commit   = (state_q == WAIT) && (cnt_q == '0);
        mem_we   = commit && is_wr_q;
        mem_re   = commit && !is_wr_q;
        for (int w = 0; w < LINE_SIZE; w++) begin
            bus.rd_line[w] = mem_rdata[w*WORD_W +: WORD_W];
        end
    end

    line_mem_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .ADDR_LEN      (ADDR_LEN)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr_q),
        .we    (mem_we),
        .wdata (wdata_q),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

endmodule
